// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the five-stage pipeline: load-use bubbles, branch flushes,
// data-memory freezes and the HALT drain sequence, plus saturating stall/flush counters.
module pipeline_hazard_controller #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_busy,
    input  logic        branch_taken,
    input  logic        id_ex_mem_read,
    input  logic [3:0]  id_ex_rd,
    input  logic [3:0]  if_id_rs,
    input  logic [3:0]  if_id_rt,
    input  logic        if_id_uses_rs,
    input  logic        if_id_uses_rt,
    input  logic        if_id_is_halt,
    output logic        pc_write_en,
    output logic        if_id_write_en,
    output logic        if_id_clear,
    output logic        id_ex_write_en,
    output logic        id_ex_clear,
    output logic        ex_mem_write_en,
    output logic        mem_wb_write_en,
    output logic        halted,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [3:0]  drain_cnt_r;
    logic [3:0]  drain_cnt_nxt_s;
    logic        halted_r;
    logic [15:0] stall_cnt_r;
    logic [15:0] flush_cnt_r;
    logic        stall_inc_s;
    logic        flush_inc_s;
    logic        load_use_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] value, input logic inc);
        logic [15:0] result;
        if (inc && (value != 16'hFFFF)) begin
            result = value + 16'd1;
        end else begin
            result = value;
        end
        return result;
    endfunction

    // R0 is hardwired to zero, so a load targeting it can never create a hazard.
    assign load_use_s = id_ex_mem_read && (id_ex_rd != 4'd0) &&
                        ((if_id_uses_rs && (if_id_rs == id_ex_rd)) ||
                         (if_id_uses_rt && (if_id_rt == id_ex_rd)));

    // Per-cycle pipeline control and next-state decision.
    always_comb begin
        pc_write_en     = 1'b1;
        if_id_write_en  = 1'b1;
        if_id_clear     = 1'b0;
        id_ex_write_en  = 1'b1;
        id_ex_clear     = 1'b0;
        ex_mem_write_en = 1'b1;
        mem_wb_write_en = 1'b1;
        state_nxt_s     = state_r;
        drain_cnt_nxt_s = drain_cnt_r;
        stall_inc_s     = 1'b0;
        flush_inc_s     = 1'b0;

        if (rst) begin
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            if_id_clear     = 1'b1;
            id_ex_write_en  = 1'b0;
            id_ex_clear     = 1'b1;
            ex_mem_write_en = 1'b0;
            mem_wb_write_en = 1'b0;
        end else begin
            case (state_r)
                RUN, DRAIN: begin
                    if (mem_busy) begin
                        // Freeze: EX keeps any branch decision stable until memory completes.
                        pc_write_en     = 1'b0;
                        if_id_write_en  = 1'b0;
                        id_ex_write_en  = 1'b0;
                        ex_mem_write_en = 1'b0;
                        mem_wb_write_en = 1'b0;
                        stall_inc_s     = 1'b1;
                    end else if (branch_taken) begin
                        if_id_clear     = 1'b1;
                        id_ex_clear     = 1'b1;
                        flush_inc_s     = 1'b1;
                        state_nxt_s     = RUN;
                        drain_cnt_nxt_s = 4'd0;
                    end else if (state_r == DRAIN) begin
                        pc_write_en     = 1'b0;
                        if_id_clear     = 1'b1;
                        drain_cnt_nxt_s = drain_cnt_r - 4'd1;
                        if (drain_cnt_r <= 4'd1) begin
                            state_nxt_s = HALTED;
                        end else begin
                            state_nxt_s = DRAIN;
                        end
                    end else if (load_use_s) begin
                        pc_write_en    = 1'b0;
                        if_id_write_en = 1'b0;
                        id_ex_clear    = 1'b1;
                        stall_inc_s    = 1'b1;
                    end else if (if_id_is_halt) begin
                        pc_write_en     = 1'b0;
                        if_id_clear     = 1'b1;
                        state_nxt_s     = DRAIN;
                        drain_cnt_nxt_s = DRAIN_LOAD;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                HALTED: begin
                    pc_write_en     = 1'b0;
                    if_id_write_en  = 1'b0;
                    id_ex_write_en  = 1'b0;
                    ex_mem_write_en = 1'b0;
                    mem_wb_write_en = 1'b0;
                end
                default: begin
                    pc_write_en     = 1'b0;
                    if_id_write_en  = 1'b0;
                    if_id_clear     = 1'b1;
                    id_ex_write_en  = 1'b0;
                    id_ex_clear     = 1'b1;
                    ex_mem_write_en = 1'b0;
                    mem_wb_write_en = 1'b0;
                    state_nxt_s     = RUN;
                    drain_cnt_nxt_s = 4'd0;
                end
            endcase
        end
    end

    // State, drain counter, halted flag and performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= RUN;
            drain_cnt_r <= 4'd0;
            halted_r    <= 1'b0;
            stall_cnt_r <= 16'd0;
            flush_cnt_r <= 16'd0;
        end else begin
            state_r     <= state_nxt_s;
            drain_cnt_r <= drain_cnt_nxt_s;
            halted_r    <= (state_nxt_s == HALTED);
            stall_cnt_r <= sat_inc(stall_cnt_r, stall_inc_s);
            flush_cnt_r <= sat_inc(flush_cnt_r, flush_inc_s);
        end
    end

    assign halted      = halted_r;
    assign stall_count = stall_cnt_r;
    assign flush_count = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench for pipeline_hazard_controller (DRAIN_CYCLES = 3).
module tb_pipeline_hazard_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_busy;
    logic        branch_taken;
    logic        id_ex_mem_read;
    logic [3:0]  id_ex_rd;
    logic [3:0]  if_id_rs;
    logic [3:0]  if_id_rt;
    logic        if_id_uses_rs;
    logic        if_id_uses_rt;
    logic        if_id_is_halt;
    logic        pc_write_en;
    logic        if_id_write_en;
    logic        if_id_clear;
    logic        id_ex_write_en;
    logic        id_ex_clear;
    logic        ex_mem_write_en;
    logic        mem_wb_write_en;
    logic        halted;
    logic [15:0] stall_count;
    logic [15:0] flush_count;
    logic [6:0]  ctl;

    int total = 0;
    int bad   = 0;

    // {pc_we, if_id_we, if_id_clr, id_ex_we, id_ex_clr, ex_mem_we, mem_wb_we}
    localparam logic [6:0] C_ADV    = 7'b1101011;
    localparam logic [6:0] C_FREEZE = 7'b0000000;
    localparam logic [6:0] C_FLUSH  = 7'b1111111;
    localparam logic [6:0] C_BUBBLE = 7'b0001111;
    localparam logic [6:0] C_DRAIN  = 7'b0111011;
    localparam logic [6:0] C_RESET  = 7'b0010100;

    pipeline_hazard_controller #(.DRAIN_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .mem_busy(mem_busy), .branch_taken(branch_taken),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .if_id_uses_rs(if_id_uses_rs), .if_id_uses_rt(if_id_uses_rt),
        .if_id_is_halt(if_id_is_halt),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en), .if_id_clear(if_id_clear),
        .id_ex_write_en(id_ex_write_en), .id_ex_clear(id_ex_clear),
        .ex_mem_write_en(ex_mem_write_en), .mem_wb_write_en(mem_wb_write_en),
        .halted(halted), .stall_count(stall_count), .flush_count(flush_count)
    );

    assign ctl = {pc_write_en, if_id_write_en, if_id_clear, id_ex_write_en,
                  id_ex_clear, ex_mem_write_en, mem_wb_write_en};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; mem_busy = 1'b0; branch_taken = 1'b0; id_ex_mem_read = 1'b0;
        id_ex_rd = 4'd0; if_id_rs = 4'd0; if_id_rt = 4'd0;
        if_id_uses_rs = 1'b0; if_id_uses_rt = 1'b0; if_id_is_halt = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        tick();
        idle();
    endtask

    // Accepts HALT from RUN, leaving the controller in DRAIN with the full count.
    task automatic accept_halt(input string tag);
        if_id_is_halt = 1'b1;
        #1;
        check({tag, "_accept_ctl"}, 32'(ctl), 32'(C_DRAIN));
        tick();
        if_id_is_halt = 1'b0;
        #1;
    endtask

    initial begin
        // Reset from an arbitrary state with noisy inputs
        idle();
        mem_busy = 1'b1; branch_taken = 1'b1; if_id_is_halt = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_ctl", 32'(ctl), 32'(C_RESET));
        tick();
        tick();
        check("rst_ctl_hold", 32'(ctl), 32'(C_RESET));
        idle();
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_stall", 32'(stall_count), 32'd0);
        check("rst_flush", 32'(flush_count), 32'd0);
        check("rst_adv", 32'(ctl), 32'(C_ADV));

        // Load-use via rt, one-cycle bubble
        id_ex_mem_read = 1'b1; id_ex_rd = 4'd3;
        if_id_rs = 4'd5; if_id_uses_rs = 1'b1; if_id_rt = 4'd3; if_id_uses_rt = 1'b1;
        #1;
        check("lu_rt_bubble", 32'(ctl), 32'(C_BUBBLE));
        tick();
        id_ex_mem_read = 1'b0;
        #1;
        check("lu_rt_next_adv", 32'(ctl), 32'(C_ADV));
        check("lu_rt_stall", 32'(stall_count), 32'd1);

        // Load to R0 never stalls
        id_ex_mem_read = 1'b1; id_ex_rd = 4'd0; if_id_rs = 4'd0; if_id_rt = 4'd0;
        #1;
        check("lu_r0_adv", 32'(ctl), 32'(C_ADV));
        tick();
        check("lu_r0_stall", 32'(stall_count), 32'd1);

        // Matching rt that is not actually read does not stall
        id_ex_rd = 4'd7; if_id_rs = 4'd2; if_id_rt = 4'd7; if_id_uses_rt = 1'b0;
        #1;
        check("lu_unused_adv", 32'(ctl), 32'(C_ADV));

        // Load-use via rs
        if_id_rs = 4'd7; if_id_uses_rs = 1'b1;
        #1;
        check("lu_rs_bubble", 32'(ctl), 32'(C_BUBBLE));
        tick();
        check("lu_rs_stall", 32'(stall_count), 32'd2);

        // Branch together with load-use: flush only
        branch_taken = 1'b1;
        #1;
        check("br_lu_ctl", 32'(ctl), 32'(C_FLUSH));
        tick();
        idle();
        check("br_lu_flush", 32'(flush_count), 32'd1);
        check("br_lu_stall", 32'(stall_count), 32'd2);

        // HALT, 4-cycle freeze in DRAIN, then 3 drain cycles
        do_reset();
        accept_halt("h1");
        check("h1_not_halted", 32'(halted), 32'd0);
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("h1_freeze%0d", i), 32'(ctl), 32'(C_FREEZE));
            tick();
        end
        mem_busy = 1'b0;
        #1;
        check("h1_freeze_stall", 32'(stall_count), 32'd4);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("h1_drain%0d_ctl", i), 32'(ctl), 32'(C_DRAIN));
            check($sformatf("h1_drain%0d_halted", i), 32'(halted), 32'd0);
            tick();
        end
        check("h1_halted", 32'(halted), 32'd1);
        check("h1_halted_ctl", 32'(ctl), 32'(C_FREEZE));
        mem_busy = 1'b1; branch_taken = 1'b1; if_id_is_halt = 1'b1;
        #1;
        check("h1_ignore_ctl", 32'(ctl), 32'(C_FREEZE));
        tick();
        tick();
        check("h1_ignore_halted", 32'(halted), 32'd1);
        check("h1_ignore_stall", 32'(stall_count), 32'd4);
        check("h1_ignore_flush", 32'(flush_count), 32'd0);

        // Reset out of HALTED
        do_reset();
        check("rst_from_halt", 32'(halted), 32'd0);
        check("rst_from_halt_ctl", 32'(ctl), 32'(C_ADV));

        // Branch on the second DRAIN cycle aborts the halt
        accept_halt("h2");
        tick();
        branch_taken = 1'b1;
        #1;
        check("h2_abort_ctl", 32'(ctl), 32'(C_FLUSH));
        tick();
        idle();
        check("h2_run_ctl", 32'(ctl), 32'(C_ADV));
        check("h2_run_flush", 32'(flush_count), 32'd1);
        id_ex_mem_read = 1'b1; id_ex_rd = 4'd4; if_id_rt = 4'd4; if_id_uses_rt = 1'b1;
        #1;
        check("h2_run_bubble", 32'(ctl), 32'(C_BUBBLE));
        tick();
        idle();
        tick();
        tick();
        check("h2_still_running", 32'(halted), 32'd0);

        // A later HALT completes after exactly 3 drain edges
        accept_halt("h3");
        tick();
        tick();
        check("h3_pre_halt", 32'(halted), 32'd0);
        tick();
        check("h3_halted", 32'(halted), 32'd1);
        mem_busy = 1'b1; branch_taken = 1'b1;
        #1;
        check("h3_ignore_ctl", 32'(ctl), 32'(C_FREEZE));
        tick();
        check("h3_ignore_halted", 32'(halted), 32'd1);
        check("h3_flush_kept", 32'(flush_count), 32'd1);

        // Stall counter saturation
        do_reset();
        mem_busy = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            tick();
        end
        check("sat_stall", 32'(stall_count), 32'h0000FFFF);
        tick();
        check("sat_stall_hold", 32'(stall_count), 32'h0000FFFF);
        check("sat_flush", 32'(flush_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
